// File: rtl/data_mem_responder.sv
// Word-organised data memory with a load/store request port and a fixed-latency response port.
// Sub-word stores merge into the addressed lanes; loads are extended according to funct3.
module data_mem_responder #(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_funct3,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int unsigned Depth = 2 ** ADDR_W;

  typedef enum logic [1:0] {StIdle, StBusy, StResp} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic [31:0] mem [Depth];

  logic              op_we;
  logic [31:0]       op_addr, op_wdata;
  logic [2:0]        op_funct3;
  logic [1:0]        lane;
  logic [ADDR_W-1:0] idx;
  logic              op_err;
  logic              accept, enter_resp;
  logic [3:0]        be;
  logic [31:0]       sdata, rword, shifted, load_data, resp_data;

  // With LATENCY = 1 the memory access happens on the accepting edge, so use the live inputs.
  always_comb begin
    if (state_q == StIdle) begin
      op_we     = req_we;
      op_addr   = req_addr;
      op_wdata  = req_wdata;
      op_funct3 = req_funct3;
    end else begin
      op_we     = we_q;
      op_addr   = addr_q;
      op_wdata  = wdata_q;
      op_funct3 = funct3_q;
    end
  end

  assign lane       = op_addr[1:0];
  assign idx        = op_addr[ADDR_W+1:2];
  assign accept     = req_valid && (state_q == StIdle);
  assign enter_resp = (accept && (LATENCY == 1)) || ((state_q == StBusy) && (cnt_q == 4'd1));

  always_comb begin
    op_err = (op_addr >> (ADDR_W + 2)) != 32'd0;
    case (op_funct3)
      3'b000:  ;
      3'b001:  if (lane[0]) op_err = 1'b1;
      3'b010:  if (lane != 2'b00) op_err = 1'b1;
      3'b100:  if (op_we) op_err = 1'b1;
      3'b101:  if (op_we || lane[0]) op_err = 1'b1;
      default: op_err = 1'b1;
    endcase
  end

  always_comb begin
    case (op_funct3[1:0])
      2'b00: begin
        be    = 4'b0001 << lane;
        sdata = {4{op_wdata[7:0]}};
      end
      2'b01: begin
        be    = 4'b0011 << lane;
        sdata = {2{op_wdata[15:0]}};
      end
      default: begin
        be    = 4'b1111;
        sdata = op_wdata;
      end
    endcase
  end

  assign rword   = mem[idx];
  assign shifted = rword >> {lane, 3'b000};

  always_comb begin
    case (op_funct3)
      3'b000:  load_data = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  load_data = {{16{shifted[15]}}, shifted[15:0]};
      3'b100:  load_data = {24'd0, shifted[7:0]};
      3'b101:  load_data = {16'd0, shifted[15:0]};
      default: load_data = rword;
    endcase
  end

  assign resp_data = (op_we || op_err) ? 32'd0 : load_data;

  // Memory is deliberately left out of reset; a reset on the RESP-entry edge blocks the write.
  always_ff @(posedge clk) begin
    if (!reset && enter_resp && op_we && !op_err) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[idx][8*i +: 8] <= sdata[8*i +: 8];
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    funct3_d = funct3_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          we_d     = req_we;
          addr_d   = req_addr;
          wdata_d  = req_wdata;
          funct3_d = req_funct3;
          cnt_d    = 4'(LATENCY - 1);
          state_d  = (LATENCY == 1) ? StResp : StBusy;
        end
      end
      StBusy: begin
        if (cnt_q == 4'd1) state_d = StResp;
        else               cnt_d   = cnt_q - 4'd1;
      end
      StResp: begin
        if (resp_ready) begin
          state_d = StIdle;
          rdata_d = 32'd0;
          err_d   = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
    if (enter_resp) begin
      rdata_d = resp_data;
      err_d   = op_err;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      cnt_q    <= 4'd0;
      we_q     <= 1'b0;
      addr_q   <= 32'd0;
      wdata_q  <= 32'd0;
      funct3_q <= 3'd0;
      rdata_q  <= 32'd0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      funct3_q <= funct3_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  assign req_ready  = (state_q == StIdle);
  assign resp_valid = (state_q == StResp);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 SHALL have parameter ADDR_W, default 8: word-address width; memory depth 2**ADDR_W 32-bit words.
REQ-002 SHALL have parameter LATENCY, default 2: cycles from request acceptance to response; legal range 1..15.
REQ-003 SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port req_valid  input  1  processor presents a load/store request.
REQ-006 SHALL have port req_ready  output  1  responder accepts a request this cycle.
REQ-007 SHALL have port req_we  input  1  1 = store, 0 = load.
REQ-008 SHALL have port req_addr  input  32  byte address.
REQ-009 SHALL have port req_wdata  input  32  store data, right-aligned (byte in [7:0], half in [15:0]).
REQ-010 SHALL have port req_funct3  input  3  RISC-V size code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-011 SHALL have port resp_valid  output  1  response available.
REQ-012 SHALL have port resp_ready  input  1  processor consumes the response.
REQ-013 SHALL have port resp_rdata  output  32  load data, extended per funct3; 0 for stores and errors.
REQ-014 SHALL have port resp_err  output  1  request faulted; no memory side effect.

Function
REQ-015 SHALL implement the states IDLE, BUSY and RESP; req_ready = 1 only in IDLE; resp_valid = 1 only in RESP.
REQ-016 SHALL accept a request on the edge where req_valid && req_ready, latch we/addr/wdata/funct3, and load a down-counter with LATENCY-1.
REQ-017 SHALL transition IDLE->RESP directly when LATENCY = 1; otherwise IDLE->BUSY.
REQ-018 SHALL transition BUSY->RESP on the edge where the counter equals 1, decrementing the counter each BUSY cycle, so that resp_valid rises exactly LATENCY edges after acceptance.
REQ-019 SHALL perform the store write and the load read on the edge entering RESP, using the latched request.
REQ-020 SHALL hold resp_valid, resp_rdata and resp_err stable in RESP until resp_ready = 1, then return to IDLE on that edge; no new request is accepted in that same cycle.
REQ-021 SHALL use little-endian byte lanes: word index addr[ADDR_W+1:2], lane addr[1:0].
REQ-022 SHALL write only the addressed byte for SB, the addressed half-word for SH, and the full word for SW; all other bytes remain unchanged.
REQ-023 SHALL sign-extend loads for LB/LH, zero-extend them for LBU/LHU, and pass LW through unchanged.
REQ-024 SHALL flag resp_err = 1 for any of the following: H/HU with addr[0] = 1; W with addr[1:0] != 0; addr[31:ADDR_W+2] != 0; funct3 in {011, 110, 111}; or a store with funct3 in {100, 101}.
REQ-025 SHALL, on error, perform no write and drive resp_rdata = 0, with latency identical to that of a non-error request.
REQ-026 SHALL ignore req_valid and all request inputs while in BUSY or RESP.

Reset
REQ-027 SHALL, while reset = 1 at an edge, enter IDLE, clear the counter and the latched request, and drive req_ready = 1 after the edge, resp_valid = 0, resp_rdata = 0 and resp_err = 0.
REQ-028 SHALL, on reset during BUSY, discard the pending store (no memory write) and the pending load.
REQ-029 SHALL NOT clear memory contents on reset.
REQ-030 SHALL give reset priority over the request handshake and the response handshake in the same cycle.

Verification
REQ-031 SHALL cover: with LATENCY = 2, SW addr 0x10 data 0xDEADBEEF, then LW addr 0x10 -> resp_valid 2 edges after each acceptance, load rdata = 0xDEADBEEF, resp_err = 0.
REQ-032 SHALL cover: SB addr 0x11 data 0x000000A5 over 0xDEADBEEF, then LW 0x10 -> 0xDEADA5EF; LB 0x11 -> 0xFFFFFFA5; LBU 0x11 -> 0x000000A5; LHU 0x12 -> 0x0000DEAD.
REQ-033 SHALL cover: LW addr 0x12, SH addr 0x13, and LW addr 0x400 with ADDR_W = 8 -> each yields resp_err = 1 and resp_rdata = 0, with memory unchanged.
REQ-034 SHALL cover: resp_ready held 0 for 5 cycles -> resp_valid/rdata stable for those 5 cycles, req_ready = 0, and a req_valid pulse during them is ignored.
REQ-035 SHALL cover: SW addr 0x20 data 0x12345678 accepted, reset asserted 1 cycle later -> no response; subsequent LW 0x20 returns the prior contents.
REQ-036 SHALL cover: with LATENCY = 1, back-to-back requests with resp_ready tied to 1 -> one request accepted every 2 cycles, resp_valid 1 edge after each acceptance.
